// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM port arbiter.
package vram_arb_pkg;

    // Which master issued a transfer; doubles as the read-return steering tag.
    typedef enum logic {
        M_DISPLAY = 1'b0,
        M_DMA     = 1'b1
    } master_id_t;

    // One slot of the read-return pipeline.
    typedef struct packed {
        logic       valid;
        master_id_t owner;
    } rd_tag_t;

    // Width of the m1 starvation counter.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag shift register: a tag entering stage 0 on the grant edge
// appears at the output exactly DEPTH cycles later, matching the RAM read
// latency, so read data can be steered to the master that issued it.
module rd_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_port_arbiter.sv
// Two-master arbiter for the single VRAM port. Master 0 (display scanout) has
// fixed priority; master 1 (fill/blit DMA) is protected by a starvation
// counter and may lock the port for bursts. Read data returns RD_LATENCY
// cycles after the accepted read, steered to the issuing master.
//
// Handshake: a transfer happens in any cycle where mX_req && mX_gnt. The grant
// is combinational in the same cycle, there is no queue, and a requesting
// master holds req/addr/wr_ena/wr_data stable until it is granted. At most
// one master is granted per cycle.
module vram_port_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_wr_ena,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_gnt,
    output logic              m0_rd_valid,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic              m1_wr_ena,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rd_valid,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              ram_wr_ena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic              locked_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              gnt0;
    logic              gnt1;
    logic              granted;
    master_id_t        granted_id;
    logic              sel_wr_ena;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wr_data;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_wr_data_q;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    // Priority chain: lock, then starvation guard, then display, then DMA.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (locked_q && m1_req) begin
                gnt1 = 1'b1;
            end else if ((wait_cnt == WAIT_LIMIT) && m1_req) begin
                gnt1 = 1'b1;
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign granted    = gnt0 || gnt1;
    assign granted_id = gnt1 ? M_DMA : M_DISPLAY;
    assign m0_gnt     = gnt0;
    assign m1_gnt     = gnt1;

    // Mux the winning master's transfer onto the RAM port.
    always_comb begin
        sel_wr_ena  = gnt1 ? m1_wr_ena  : m0_wr_ena;
        sel_addr    = gnt1 ? m1_addr    : m0_addr;
        sel_wr_data = gnt1 ? m1_wr_data : m0_wr_data;
        ram_wr_ena  = granted && sel_wr_ena;
        ram_addr    = granted ? sel_addr    : hold_addr_q;
        ram_wr_data = granted ? sel_wr_data : hold_wr_data_q;
    end

    // Remember the last driven address/data so an idle port does not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr_q    <= '0;
            hold_wr_data_q <= '0;
        end else if (granted) begin
            hold_addr_q    <= sel_addr;
            hold_wr_data_q <= sel_wr_data;
        end
    end

    // Count consecutive cycles m1 is kept waiting, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!m1_req || gnt1) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Burst lock: taken on a locked m1 grant, released when m1 lets go.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q <= 1'b0;
        end else if (gnt1 && m1_lock) begin
            locked_q <= 1'b1;
        end else if (!m1_req || !m1_lock) begin
            locked_q <= 1'b0;
        end
    end

    // Tag every accepted read with its owner; writes enter as empty slots.
    always_comb begin
        tag_in       = '0;
        tag_in.valid = granted && !sel_wr_ena;
        tag_in.owner = granted_id;
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign m0_rd_valid = !rst && tag_out.valid && (tag_out.owner == M_DISPLAY);
    assign m1_rd_valid = !rst && tag_out.valid && (tag_out.owner == M_DMA);
    assign m0_rd_data  = ram_rd_data;
    assign m1_rd_data  = ram_rd_data;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: instance 0 runs with RD_LATENCY = 1,
// instance 1 with RD_LATENCY = 3; each has its own behavioural RAM.
module tb_vram_port_arbiter;

    logic clk;
    logic rst;

    logic [1:0]       m0_req, m0_wr_ena, m0_gnt, m0_rd_valid;
    logic [1:0][16:0] m0_addr;
    logic [1:0][7:0]  m0_wr_data, m0_rd_data;
    logic [1:0]       m1_req, m1_wr_ena, m1_lock, m1_gnt, m1_rd_valid;
    logic [1:0][16:0] m1_addr;
    logic [1:0][7:0]  m1_wr_data, m1_rd_data;
    logic [1:0]       ram_wr_ena;
    logic [1:0][16:0] ram_addr;
    logic [1:0][7:0]  ram_wr_data, ram_rd_data;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        vram_port_arbiter #(
            .ADDR_W     (17),
            .DATA_W     (8),
            .RD_LATENCY ((g == 0) ? 1 : 3),
            .MAX_WAIT   (15)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .m0_req      (m0_req[g]),
            .m0_wr_ena   (m0_wr_ena[g]),
            .m0_addr     (m0_addr[g]),
            .m0_wr_data  (m0_wr_data[g]),
            .m0_gnt      (m0_gnt[g]),
            .m0_rd_valid (m0_rd_valid[g]),
            .m0_rd_data  (m0_rd_data[g]),
            .m1_req      (m1_req[g]),
            .m1_wr_ena   (m1_wr_ena[g]),
            .m1_addr     (m1_addr[g]),
            .m1_wr_data  (m1_wr_data[g]),
            .m1_lock     (m1_lock[g]),
            .m1_gnt      (m1_gnt[g]),
            .m1_rd_valid (m1_rd_valid[g]),
            .m1_rd_data  (m1_rd_data[g]),
            .ram_wr_ena  (ram_wr_ena[g]),
            .ram_addr    (ram_addr[g]),
            .ram_wr_data (ram_wr_data[g]),
            .ram_rd_data (ram_rd_data[g])
        );
    end

    // ---------------- RAM models (preloaded while rst is high) ----------------
    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];
    logic [7:0] pipe0;
    logic [7:0] pipe1 [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem0[i] <= 8'h00;
            mem0[10'h010] <= 8'hA5;
        end else if (ram_wr_ena[0]) begin
            mem0[ram_addr[0][9:0]] <= ram_wr_data[0];
        end
        pipe0 <= mem0[ram_addr[0][9:0]];
    end
    assign ram_rd_data[0] = pipe0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem1[i] <= 8'h00;
            mem1[10'h000] <= 8'h01;
            mem1[10'h001] <= 8'h02;
        end else if (ram_wr_ena[1]) begin
            mem1[ram_addr[1][9:0]] <= ram_wr_data[1];
        end
        pipe1[0] <= mem1[ram_addr[1][9:0]];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign ram_rd_data[1] = pipe1[2];

    // ---------------- driver tasks ----------------
    task automatic drive_m0(input int g, input logic req, input logic wr,
                            input logic [16:0] addr, input logic [7:0] data);
        m0_req[g] = req; m0_wr_ena[g] = wr; m0_addr[g] = addr; m0_wr_data[g] = data;
    endtask

    task automatic drive_m1(input int g, input logic req, input logic wr, input logic lock,
                            input logic [16:0] addr, input logic [7:0] data);
        m1_req[g] = req; m1_wr_ena[g] = wr; m1_lock[g] = lock;
        m1_addr[g] = addr; m1_wr_data[g] = data;
    endtask

    task automatic drive_idle(input int g);
        drive_m0(g, 1'b0, 1'b0, 17'h0, 8'h0);
        drive_m1(g, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
    endtask

    // ---------------- scoreboard ----------------
    // Pops and compares read returns, then records reads accepted this cycle.
    task automatic sb_inst(input int g);
        logic [8:0] e;
        logic [8:0] obs;
        logic [7:0] rd;
        if (m0_rd_valid[g] || m1_rd_valid[g]) begin
            checks++;
            obs = {m1_rd_valid[g], m1_rd_valid[g] ? m1_rd_data[g] : m0_rd_data[g]};
            if (m0_rd_valid[g] && m1_rd_valid[g]) begin
                errors++;
                $display("FAIL sb_both_valid inst%0d: got both rd_valid expected one", g);
            end else if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
                errors++;
                $display("FAIL sb_unexpected inst%0d: got return %0h expected none", g, obs);
            end else begin
                e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL sb_return inst%0d: got owner/data %0h expected %0h", g, obs, e);
                end
            end
        end
        if (m0_req[g] && m0_gnt[g] && !m0_wr_ena[g]) begin
            rd = (g == 0) ? mem0[m0_addr[g][9:0]] : mem1[m0_addr[g][9:0]];
            if (g == 0) exp_q0.push_back({1'b0, rd}); else exp_q1.push_back({1'b0, rd});
        end
        if (m1_req[g] && m1_gnt[g] && !m1_wr_ena[g]) begin
            rd = (g == 0) ? mem0[m1_addr[g][9:0]] : mem1[m1_addr[g][9:0]];
            if (g == 0) exp_q0.push_back({1'b1, rd}); else exp_q1.push_back({1'b1, rd});
        end
    endtask

    task automatic scoreboard_step();
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            checks++;
            if ((m0_rd_valid | m1_rd_valid) !== 2'b00) begin
                errors++;
                $display("FAIL sb_reset_valid: got %0b/%0b expected 00/00", m0_rd_valid, m1_rd_valid);
            end
        end else begin
            sb_inst(0);
            sb_inst(1);
        end
    endtask

    // Scoreboard runs on the falling edge; inputs change 1 ns after the rising edge.
    task automatic next_cycle();
        @(negedge clk);
        scoreboard_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_m0(0, 1'b1, 1'b0, 17'h0, 8'h0);
        drive_m1(0, 1'b1, 1'b0, 1'b0, 17'h0, 8'h0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if ({m0_gnt[0], m1_gnt[0], m0_rd_valid[0], m1_rd_valid[0], ram_wr_ena[0]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %0b%0b%0b%0b%0b expected 00000", m0_gnt[0],
                         m1_gnt[0], m0_rd_valid[0], m1_rd_valid[0], ram_wr_ena[0]);
            end
            checks++;
            if (ram_addr[0] !== 17'h0 || ram_wr_data[0] !== 8'h0) begin
                errors++;
                $display("FAIL reset_ram_bus: got %0h/%0h expected 0/0", ram_addr[0], ram_wr_data[0]);
            end
            next_cycle();
        end
        rst = 1'b0;
        #2;
        checks++;
        if (m0_gnt[0] !== 1'b1 || m1_gnt[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_gnt: got m0 %0b m1 %0b expected m0 1 m1 0", m0_gnt[0], m1_gnt[0]);
        end
        next_cycle();
        drive_idle(0);
        next_cycle();
    endtask

    task automatic test_priority_latency();
        drive_m0(0, 1'b1, 1'b0, 17'h00010, 8'h0);
        #2;
        checks++;
        if (m0_gnt[0] !== 1'b1 || m1_gnt[0] !== 1'b0 || ram_addr[0] !== 17'h00010) begin
            errors++;
            $display("FAIL lat_grant: got gnt %0b%0b addr %0h expected 10 addr 10",
                     m0_gnt[0], m1_gnt[0], ram_addr[0]);
        end
        next_cycle();
        drive_idle(0);
        #2;
        checks++;
        if (m0_rd_valid[0] !== 1'b1 || m0_rd_data[0] !== 8'hA5 || m1_rd_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_return: got v0 %0b d %0h v1 %0b expected v0 1 d a5 v1 0",
                     m0_rd_valid[0], m0_rd_data[0], m1_rd_valid[0]);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        int m1_wins;
        logic exp_m1;
        m1_wins = 0;
        drive_m0(0, 1'b1, 1'b0, 17'h00010, 8'h0);
        drive_m1(0, 1'b1, 1'b0, 1'b0, 17'h00010, 8'h0);
        for (int i = 0; i < 48; i++) begin
            #2;
            exp_m1 = ((i % 16) == 15);
            checks++;
            if (m1_gnt[0] !== exp_m1 || m0_gnt[0] !== !exp_m1) begin
                errors++;
                $display("FAIL starve_gnt cycle %0d: got m0 %0b m1 %0b expected m1 %0b",
                         i, m0_gnt[0], m1_gnt[0], exp_m1);
            end
            checks++;
            if (g_dut[0].u_dut.wait_cnt !== 8'(i % 16)) begin
                errors++;
                $display("FAIL starve_wait_cnt cycle %0d: got %0d expected %0d",
                         i, g_dut[0].u_dut.wait_cnt, i % 16);
            end
            if (m1_gnt[0] === 1'b1) m1_wins++;
            next_cycle();
        end
        checks++;
        if (m1_wins != 3) begin
            errors++;
            $display("FAIL starve_count: got %0d expected 3", m1_wins);
        end
        drive_idle(0);
        next_cycle();
    endtask

    task automatic test_lock_burst();
        int k;
        k = 0;
        drive_m0(0, 1'b1, 1'b0, 17'h00010, 8'h0);
        for (int c = 0; c < 40 && k < 8; c++) begin
            drive_m1(0, 1'b1, 1'b1, 1'b1, 17'(32'h100 + k), 8'h11);
            #2;
            if (k > 0) begin
                checks++;
                if (m1_gnt[0] !== 1'b1 || m0_gnt[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_burst beat %0d: got m0 %0b m1 %0b expected m0 0 m1 1",
                             k, m0_gnt[0], m1_gnt[0]);
                end
            end
            if (m1_gnt[0] === 1'b1) k++;
            next_cycle();
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL lock_timeout: got %0d beats expected 8", k);
        end
        drive_m1(0, 1'b0, 1'b0, 1'b0, 17'h0, 8'h0);
        #2;
        checks++;
        if (m0_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL lock_release_m0: got %0b expected 1", m0_gnt[0]);
        end
        next_cycle();
        drive_idle(0);
        checks++;
        if (g_dut[0].u_dut.locked_q !== 1'b0) begin
            errors++;
            $display("FAIL lock_cleared: got %0b expected 0", g_dut[0].u_dut.locked_q);
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (mem0[10'h100 + j] !== 8'h11) begin
                errors++;
                $display("FAIL lock_ram addr %0h: got %0h expected 11", 32'h100 + j, mem0[10'h100 + j]);
            end
        end
        next_cycle();
    endtask

    task automatic test_hold();
        drive_m1(0, 1'b1, 1'b1, 1'b0, 17'h00030, 8'h55);
        #2;
        checks++;
        if (m1_gnt[0] !== 1'b1 || ram_wr_ena[0] !== 1'b1 || ram_addr[0] !== 17'h30 || ram_wr_data[0] !== 8'h55) begin
            errors++;
            $display("FAIL hold_write: got g %0b we %0b a %0h d %0h expected 1 1 30 55",
                     m1_gnt[0], ram_wr_ena[0], ram_addr[0], ram_wr_data[0]);
        end
        next_cycle();
        drive_m1(0, 1'b0, 1'b1, 1'b0, 17'h00031, 8'h66);
        #2;
        checks++;
        if (ram_wr_ena[0] !== 1'b0 || ram_addr[0] !== 17'h30 || ram_wr_data[0] !== 8'h55) begin
            errors++;
            $display("FAIL hold_idle: got we %0b a %0h d %0h expected 0 30 55",
                     ram_wr_ena[0], ram_addr[0], ram_wr_data[0]);
        end
        next_cycle();
        drive_idle(0);
    endtask

    task automatic test_interleaved();
        logic ev0, ev1;
        for (int c = 0; c < 13; c++) begin
            drive_idle(1);
            if (c < 6 && (c % 2) == 0) drive_m0(1, 1'b1, 1'b0, 17'h0, 8'h0);
            if (c < 6 && (c % 2) == 1) drive_m1(1, 1'b1, 1'b0, 1'b0, 17'h1, 8'h0);
            if (c == 6) drive_m0(1, 1'b1, 1'b1, 17'h20, 8'h77);
            if (c == 7) drive_m1(1, 1'b1, 1'b1, 1'b0, 17'h21, 8'h88);
            #2;
            if (c < 8) begin
                checks++;
                if (m0_gnt[1] !== ((c % 2) == 0) || m1_gnt[1] !== ((c % 2) == 1)) begin
                    errors++;
                    $display("FAIL inter_gnt cycle %0d: got m0 %0b m1 %0b", c, m0_gnt[1], m1_gnt[1]);
                end
            end
            ev0 = (c == 3 || c == 5 || c == 7);
            ev1 = (c == 4 || c == 6 || c == 8);
            checks++;
            if (m0_rd_valid[1] !== ev0 || m1_rd_valid[1] !== ev1) begin
                errors++;
                $display("FAIL inter_valid cycle %0d: got %0b%0b expected %0b%0b",
                         c, m0_rd_valid[1], m1_rd_valid[1], ev0, ev1);
            end
            if (ev0) begin
                checks++;
                if (m0_rd_data[1] !== 8'h01) begin
                    errors++;
                    $display("FAIL inter_m0_data cycle %0d: got %0h expected 01", c, m0_rd_data[1]);
                end
            end
            if (ev1) begin
                checks++;
                if (m1_rd_data[1] !== 8'h02) begin
                    errors++;
                    $display("FAIL inter_m1_data cycle %0d: got %0h expected 02", c, m1_rd_data[1]);
                end
            end
            next_cycle();
        end
        drive_idle(1);
    endtask

    task automatic test_reset_midflight();
        drive_m1(0, 1'b1, 1'b0, 1'b1, 17'h00010, 8'h0);
        #2;
        checks++;
        if (m1_gnt[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue: got %0b expected 1", m1_gnt[0]);
        end
        next_cycle();
        rst = 1'b1;
        #2;
        checks++;
        if (m1_gnt[0] !== 1'b0 || m1_rd_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_cycle: got gnt %0b v %0b expected 0 0", m1_gnt[0], m1_rd_valid[0]);
        end
        next_cycle();
        checks++;
        if (g_dut[0].u_dut.locked_q !== 1'b0 || g_dut[0].u_dut.wait_cnt !== 8'h0) begin
            errors++;
            $display("FAIL mid_state: got lock %0b wait %0d expected 0 0",
                     g_dut[0].u_dut.locked_q, g_dut[0].u_dut.wait_cnt);
        end
        rst = 1'b0;
        drive_idle(0);
        for (int c = 0; c < 6; c++) begin
            #2;
            checks++;
            if (m1_rd_valid[0] !== 1'b0 || m0_rd_valid[0] !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_return cycle %0d: got %0b%0b expected 00",
                         c, m0_rd_valid[0], m1_rd_valid[0]);
            end
            next_cycle();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst = 1'b1;
        drive_idle(0);
        drive_idle(1);
        test_reset();
        test_priority_latency();
        test_starvation();
        test_lock_burst();
        test_hold();
        test_interleaved();
        test_reset_midflight();
        for (int c = 0; c < 5; c++) next_cycle();
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
